// File: rtl/dm_be_responder.sv
// Data-memory responder for the MEM stage: byte-masked stores, extended loads,
// req/busy/ack handshake with a fixed number of wait states before each access.
module dm_be_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        ack_o,
  output logic [31:0] rdata_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAITS = 2'd1,
    ACC   = 2'd2
  } state_t;

  localparam int          DEPTH      = 1 << ADDR_W;
  localparam logic [3:0]  CNT_RELOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_busy;
  logic                r_ack;
  logic [31:0]         r_rdata;
  logic                r_we;
  logic [ADDR_W-1:0]   r_idx;
  logic [3:0]          r_be;
  logic                r_sign;
  logic [31:0]         r_wdata;
  logic [31:0]         r_mem [DEPTH];

  logic [31:0]         w_word;
  logic [31:0]         w_lanes;
  logic [31:0]         w_bitmask;
  logic [31:0]         w_new_word;
  logic [31:0]         w_load;
  logic                w_commit;

  assign w_word   = r_mem[r_idx];
  assign w_commit = (r_state == ACC) && r_we;

  // Store steering: place the right-aligned data on the lanes named by be.
  always_comb begin
    w_lanes = r_wdata;
    unique case (r_be)
      4'b1100:                            w_lanes = {r_wdata[15:0], 16'h0000};
      4'b0001, 4'b0010, 4'b0100, 4'b1000: w_lanes = {4{r_wdata[7:0]}};
      default:                            w_lanes = r_wdata;
    endcase
  end

  assign w_bitmask  = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};
  assign w_new_word = (w_word & ~w_bitmask) | (w_lanes & w_bitmask);

  // Load extraction: unrecognised enable patterns return the raw word.
  always_comb begin
    w_load = w_word;
    unique case (r_be)
      4'b0011: w_load = {{16{r_sign & w_word[15]}}, w_word[15:0]};
      4'b1100: w_load = {{16{r_sign & w_word[31]}}, w_word[31:16]};
      4'b0001: w_load = {{24{r_sign & w_word[7]}},  w_word[7:0]};
      4'b0010: w_load = {{24{r_sign & w_word[15]}}, w_word[15:8]};
      4'b0100: w_load = {{24{r_sign & w_word[23]}}, w_word[23:16]};
      4'b1000: w_load = {{24{r_sign & w_word[31]}}, w_word[31:24]};
      default: w_load = w_word;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_rdata <= 32'h0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_be    <= 4'h0;
      r_sign  <= 1'b0;
      r_wdata <= 32'h0;
    end else begin
      r_ack <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (req_i) begin
            r_we    <= we_i;
            r_idx   <= addr_i[ADDR_W+1:2];
            r_be    <= be_i;
            r_sign  <= sign_i;
            r_wdata <= wdata_i;
            r_busy  <= 1'b1;
            if (WAIT > 0) begin
              r_state <= WAITS;
              r_cnt   <= CNT_RELOAD;
            end else begin
              r_state <= ACC;
            end
          end
        end
        WAITS: begin
          if (r_cnt == 4'd0) begin
            r_state <= ACC;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ACC: begin
          if (!r_we) begin
            r_rdata <= w_load;
          end
          r_ack   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the array is deliberately not reset; reset only suppresses the commit,
  // so a write pending on the reset edge is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (w_commit) begin
      r_mem[r_idx] <= w_new_word;
    end
  end

  assign busy_o  = r_busy;
  assign ack_o   = r_ack;
  assign rdata_o = r_rdata;

endmodule

// File: tb/tb_dm_be_responder.sv
// Directed bench for dm_be_responder: table of load/store vectors on a WAIT=2
// instance plus hand sequences for reset abort, held req and a WAIT=0 instance.
module tb_dm_be_responder;

  logic        clk;
  logic        rst_n;
  logic        req, we, sign;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        busy, ack;
  logic [31:0] rdata;

  logic        req0, we0, sign0;
  logic [31:0] addr0, wdata0;
  logic [3:0]  be0;
  logic        busy0, ack0;
  logic [31:0] rdata0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  dm_be_responder #(.ADDR_W(10), .WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .be_i(be), .sign_i(sign), .wdata_i(wdata),
    .busy_o(busy), .ack_o(ack), .rdata_o(rdata)
  );

  dm_be_responder #(.ADDR_W(10), .WAIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_i(req0), .we_i(we0), .addr_i(addr0),
    .be_i(be0), .sign_i(sign0), .wdata_i(wdata0),
    .busy_o(busy0), .ack_o(ack0), .rdata_o(rdata0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        sign;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on the selected instance; returns edges from accept to ack and
  // the number of busy cycles seen before the ack.
  task automatic access(input bit use0, input vec_t v, output int lat, output int bcnt);
    @(negedge clk);
    if (use0) begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; be0 = v.be; sign0 = v.sign; wdata0 = v.wdata;
    end else begin
      req = 1'b1; we = v.we; addr = v.addr; be = v.be; sign = v.sign; wdata = v.wdata;
    end
    @(posedge clk); #1;
    req = 1'b0; req0 = 1'b0;
    lat = 0; bcnt = 0;
    while ((use0 ? ack0 : ack) !== 1'b1 && lat < 20) begin
      if ((use0 ? busy0 : busy) === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic reset_abort_test();
    int acks;
    int lat, bcnt;
    vec_t v;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h10; be = 4'b1111; sign = 1'b0; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req = 1'b0;
    check("rst_busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy_now", {31'd0, busy}, 32'd0);
    check("rst_ack_now", {31'd0, ack}, 32'd0);
    check("rst_rdata_now", rdata, 32'h0);
    acks = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
    end
    check("rst_no_ack", acks, 0);
    v = '{we: 1'b0, addr: 32'h10, be: 4'b1111, sign: 1'b0, wdata: 32'h0, exp_rdata: 32'h11223344};
    access(1'b0, v, lat, bcnt);
    check("rst_lw_after", rdata, 32'h11223344);
  endtask

  task automatic held_req_test();
    int e0, e1, n;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10; be = 4'b1111; sign = 1'b0; wdata = 32'h0;
    @(posedge clk); #1;
    e0 = cyc;
    we = 1'b1; addr = 32'h20; be = 4'b0100; sign = 1'b1; wdata = 32'h0BADF00D;
    n = 0;
    while (ack !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    check("hold_ack1_gap", cyc - e0, 3);
    check("hold_rdata1", rdata, 32'h80013344);
    e1 = cyc;
    we = 1'b0; addr = 32'h20; be = 4'b1111; sign = 1'b0;
    @(posedge clk); #1;
    check("hold_busy2", {31'd0, busy}, 32'd1);
    n = 0;
    while (ack !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    req = 1'b0;
    check("hold_ack_period", cyc - e1, 4);
    check("hold_rdata2", rdata, 32'hC5341234);
    @(posedge clk); #1;
    check("hold_no_third", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat, bcnt;
    vec_t v;
    vecs[0]  = '{1'b1, 32'h10, 4'b1111, 1'b0, 32'h11223344, 32'h00000000};
    vecs[1]  = '{1'b0, 32'h10, 4'b1111, 1'b0, 32'h0,        32'h11223344};
    vecs[2]  = '{1'b1, 32'h12, 4'b0100, 1'b0, 32'h000000AB, 32'h11223344};
    vecs[3]  = '{1'b0, 32'h10, 4'b1111, 1'b0, 32'h0,        32'h11AB3344};
    vecs[4]  = '{1'b0, 32'h12, 4'b0100, 1'b1, 32'h0,        32'hFFFFFFAB};
    vecs[5]  = '{1'b0, 32'h12, 4'b0100, 1'b0, 32'h0,        32'h000000AB};
    vecs[6]  = '{1'b1, 32'h12, 4'b1100, 1'b0, 32'h00008001, 32'h000000AB};
    vecs[7]  = '{1'b0, 32'h10, 4'b1111, 1'b0, 32'h0,        32'h80013344};
    vecs[8]  = '{1'b0, 32'h12, 4'b1100, 1'b1, 32'h0,        32'hFFFF8001};
    vecs[9]  = '{1'b0, 32'h12, 4'b1100, 1'b0, 32'h0,        32'h00008001};
    vecs[10] = '{1'b0, 32'h10, 4'b0011, 1'b1, 32'h0,        32'h00003344};
    vecs[11] = '{1'b0, 32'h10, 4'b0101, 1'b1, 32'h0,        32'h80013344};
    vecs[12] = '{1'b0, 32'h10, 4'b0011, 1'b0, 32'h0,        32'h00003344};
    vecs[13] = '{1'b1, 32'h10, 4'b0000, 1'b0, 32'hFFFFFFFF, 32'h00003344};
    vecs[14] = '{1'b0, 32'h10, 4'b1111, 1'b0, 32'h0,        32'h80013344};
    vecs[15] = '{1'b1, 32'h20, 4'b1111, 1'b0, 32'h00FF7F80, 32'h80013344};
    vecs[16] = '{1'b0, 32'h20, 4'b0001, 1'b1, 32'h0,        32'hFFFFFF80};
    vecs[17] = '{1'b0, 32'h21, 4'b0010, 1'b1, 32'h0,        32'h0000007F};
    vecs[18] = '{1'b0, 32'h20, 4'b0011, 1'b1, 32'h0,        32'h00007F80};
    vecs[19] = '{1'b1, 32'h23, 4'b1000, 1'b0, 32'h000000C5, 32'h00007F80};
    vecs[20] = '{1'b0, 32'h23, 4'b1000, 1'b1, 32'h0,        32'hFFFFFFC5};
    vecs[21] = '{1'b1, 32'h20, 4'b0110, 1'b0, 32'h12345678, 32'hFFFFFFC5};
    vecs[22] = '{1'b0, 32'h20, 4'b1111, 1'b0, 32'h0,        32'hC5345680};
    vecs[23] = '{1'b1, 32'h20, 4'b0011, 1'b0, 32'hAAAA1234, 32'hC5345680};
    vecs[24] = '{1'b0, 32'h20, 4'b1111, 1'b0, 32'h0,        32'hC5341234};

    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = 32'h0; be = 4'h0; sign = 1'b0; wdata = 32'h0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; be0 = 4'h0; sign0 = 1'b0; wdata0 = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ack", {31'd0, ack}, 32'd0);
    check("reset_rdata", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      if (i == 2) reset_abort_test();
      access(1'b0, vecs[i], lat, bcnt);
      check($sformatf("vec%0d_latency", i), lat, 3);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, 3);
      check($sformatf("vec%0d_busy_at_ack", i), {31'd0, busy}, 32'd0);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
    end

    held_req_test();

    v = '{we: 1'b1, addr: 32'h40, be: 4'b1111, sign: 1'b0, wdata: 32'hCAFEF00D, exp_rdata: 32'h0};
    access(1'b1, v, lat, bcnt);
    check("w0_write_latency", lat, 1);
    check("w0_write_rdata", rdata0, 32'h0);
    v = '{we: 1'b0, addr: 32'h40, be: 4'b0011, sign: 1'b1, wdata: 32'h0, exp_rdata: 32'h0};
    access(1'b1, v, lat, bcnt);
    check("w0_read_latency", lat, 1);
    check("w0_read_busy_cycles", bcnt, 1);
    check("w0_read_rdata", rdata0, 32'hFFFFF00D);
    @(posedge clk); #1;
    check("w0_ack_one_cycle", {31'd0, ack0}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
